// File: rtl/uart_rx_core.sv
// UART receive front end: 2-flop synchroniser, 8-bit frame deserialiser with optional
// even parity, and a small first-word-fall-through FIFO with sticky error flags.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       overrun,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitIdle
    } state_e;

    logic            rxd_meta;
    logic            rxd_s;
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_bad_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AddrW:0]  wr_ptr_q;
    logic [AddrW:0]  rd_ptr_q;

    logic tick, stop_smp, push, pop, wr_ok, ovr_set, par_set, frm_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Stop-sample outcomes act on the same edge as the sample.
    always_comb begin
        tick     = (cnt_q == '0);
        stop_smp = (state_q == StStop) && tick;
        push     = stop_smp && rxd_s && !par_bad_q;
        par_set  = stop_smp && rxd_s && par_bad_q;
        frm_set  = stop_smp && !rxd_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bad_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rxd_s) begin
                        state_q   <= StStart;
                        cnt_q     <= HalfLoad;
                        par_bad_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rxd_s) begin
                        state_q   <= StData;
                        cnt_q     <= FullLoad;
                        bit_idx_q <= 3'd0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StData: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        cnt_q   <= FullLoad;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= (PARITY_EN != 0) ? StParity : StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        par_bad_q <= rxd_s ^ (^shift_q);
                        state_q   <= StStop;
                        cnt_q     <= FullLoad;
                    end
                end
                StStop: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // A low stop bit may be a break; hold off until the line idles.
                        state_q <= rxd_s ? StIdle : StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (rxd_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rx_empty = (wr_ptr_q == rd_ptr_q);
        rx_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        pop      = rd_en && !rx_empty;
        wr_ok    = push && (!rx_full || pop);
        ovr_set  = push && rx_full && !pop;
        rd_data  = rx_empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            overrun    <= ovr_set | (overrun    & ~err_clr);
            parity_err <= par_set | (parity_err & ~err_clr);
            frame_err  <= frm_set | (frame_err  & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised scoreboard bench for uart_rx_core: a frame-level model predicts received
// bytes and sticky flags; a monitor drains the FIFO and checks bytes in order.
module tb_uart_rx_core;

    localparam int C = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, rxd, err_clr, tb_rd, mon_rd, rd_en;
    logic [7:0] rd_data;
    logic       rx_empty, rx_full, overrun, parity_err, frame_err;

    assign rd_en = tb_rd | mon_rd;

    uart_rx_core #(.CLKS_PER_BIT(C), .PARITY_EN(1), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rd_data    (rd_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .overrun    (overrun),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    bit         drain = 1'b0;
    bit         exp_ovr, exp_par, exp_frm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: whenever draining and the FIFO presents a byte, compare and pop it.
    initial begin
        mon_rd = 1'b0;
        forever begin
            @(negedge clk);
            mon_rd = 1'b0;
            if (drain && !rst && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h want none", rd_data);
                end else begin
                    check("rx_byte", rd_data, exp_q.pop_front());
                end
                mon_rd = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 good, 1 bad parity, 2 stop bit 0 (line left low on return).
    task automatic send_frame(input logic [7:0] data, input int kind, input bit pop,
                              input bit chk);
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            tick(C);
        end
        rxd = (kind == 1) ? ~(^data) : ^data;
        tick(C);
        rxd = (kind == 2) ? 1'b0 : 1'b1;
        case (kind)
            0: if (!pop && exp_q.size() >= D) exp_ovr = 1'b1;
               else exp_q.push_back(data);
            1: exp_par = 1'b1;
            default: exp_frm = 1'b1;
        endcase
        // Stop sample lands 3 + C/2 edges into the stop bit (2 sync flops + IDLE detect).
        tick(2 + C / 2);
        if (chk) check("pre_push_empty", rx_empty, 1'b1);
        if (pop) begin
            check("collide_head", rd_data, exp_q.pop_front());
            tb_rd = 1'b1;
        end
        tick(1);
        tb_rd = 1'b0;
        if (chk) check("push_timing_empty", rx_empty, 1'b0);
        tick(C - 3 - C / 2);
    endtask

    task automatic check_flags(input string name);
        check({name, "_ovr"}, overrun, exp_ovr);
        check({name, "_par"}, parity_err, exp_par);
        check({name, "_frm"}, frame_err, exp_frm);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_par = 1'b0;
        exp_frm = 1'b0;
        check_flags("cleared");
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        tick(2);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_empty"}, rx_empty, 1'b1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_data"}, rd_data, 8'h00);
        check({name, "_empty"}, rx_empty, 1'b1);
        check({name, "_full"}, rx_full, 1'b0);
        check_flags(name);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; err_clr = 1'b0; tb_rd = 1'b0;
        exp_ovr = 1'b0; exp_par = 1'b0; exp_frm = 1'b0;
        tick(3);
        check_reset("reset");
        rst = 1'b0;
        tick(2);

        // Good frame with push timing, then a manual pop.
        send_frame(8'h0F, 0, 1'b0, 1'b1);
        check("good_data", rd_data, 8'h0F);
        check_flags("good");
        tb_rd = 1'b1;
        tick(1);
        tb_rd = 1'b0;
        void'(exp_q.pop_front());
        check("good_popped", rx_empty, 1'b1);
        drain = 1'b1;

        // Parity error, then clear.
        send_frame(8'hA5, 1, 1'b0, 1'b0);
        check_flags("parity");
        check("parity_empty", rx_empty, 1'b1);
        clear_errors();

        // Framing error followed by a long break, then recovery.
        send_frame(8'h3C, 2, 1'b0, 1'b0);
        tick(40 * C);
        check_flags("break");
        check("break_empty", rx_empty, 1'b1);
        rxd = 1'b1;
        tick(2 * C);
        send_frame(8'h55, 0, 1'b0, 1'b0);
        wait_drain("recover");
        clear_errors();

        // Overrun: five back-to-back frames, no reads.
        drain = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0, 1'b0, 1'b0);
            if (i == 4) check("full_after4", rx_full, 1'b1);
        end
        check_flags("overrun");
        drain = 1'b1;
        wait_drain("overrun");
        clear_errors();

        // Short glitch must not start a frame.
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(2 * C);
        check_flags("glitch");
        check("glitch_empty", rx_empty, 1'b1);

        // Push and pop on the same edge while full.
        drain = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 0, 1'b0, 1'b0);
        check("collide_full_before", rx_full, 1'b1);
        send_frame(8'($urandom), 0, 1'b1, 1'b0);
        check_flags("collide");
        check("collide_full_after", rx_full, 1'b1);
        drain = 1'b1;
        wait_drain("collide");

        // Mid-frame reset with a byte buffered and a flag set.
        drain = 1'b0;
        send_frame(8'h99, 0, 1'b0, 1'b0);
        send_frame(8'h66, 1, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1 ^ i[0];
            tick(C);
        end
        rxd = 1'b1;
        tick(C / 2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_ovr = 1'b0; exp_par = 1'b0; exp_frm = 1'b0;
        check_reset("midreset");
        rxd = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        drain = 1'b1;
        send_frame(8'hC3, 0, 1'b0, 1'b0);
        wait_drain("after_reset");

        // Random mix of good, parity-bad and framing-bad frames.
        for (int n = 0; n < 16; n++) begin
            int k;
            k = $urandom_range(0, 5);
            send_frame(8'($urandom), (k < 4) ? 0 : k - 3, 1'b0, 1'b0);
            if (k == 5) begin
                rxd = 1'b1;
                tick(2 * C);
            end
            check_flags("rand");
            if (exp_par || exp_frm) clear_errors();
        end
        wait_drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive front end for the APB UART. Takes the asynchronous `rxd` pin, deserialises 8-bit frames (start, 8 data bits LSB first, optional even parity, 1 stop bit), and buffers good bytes in a small first-word-fall-through FIFO. The APB register block drains that FIFO and reads sticky error status. The block sits directly between the `rxd` pin and the APB UART register/readback logic.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit period. Must be even and ≥ 4.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits; 0 means no parity bit.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of 2 and ≥ 2.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: serial input. Asynchronous to `clk`; idles high.
- `rd_en` in 1: pops the FIFO head in this cycle. Ignored when `rx_empty` is high.
- `err_clr` in 1: clears `overrun`, `parity_err` and `frame_err`.
- `rd_data` out 8: FIFO head, first-word fall-through. Reads 8'h00 while empty.
- `rx_empty` out 1: FIFO holds 0 entries.
- `rx_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `overrun` out 1: sticky. A good byte was dropped because the FIFO was full.
- `parity_err` out 1: sticky. A frame was discarded on parity mismatch.
- `frame_err` out 1: sticky. A frame was discarded because its stop bit was 0.

## Operation
- **Synchroniser.** `rxd` passes through 2 flops to give `rxd_s`. Both flops reset to 1.
- **Bit timer.** One counter, width clog2(`CLKS_PER_BIT`), reloaded on every state entry.
- **State machine.** States are IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: if `rxd_s`=0, go to START and load the counter for `CLKS_PER_BIT`/2 cycles.
  - START: at expiry, sample `rxd_s` (mid start bit). If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: sample once every `CLKS_PER_BIT` cycles into a shift register, LSB first. After bit 7, go to PARITY if `PARITY_EN`=1, else STOP.
  - PARITY: sample after `CLKS_PER_BIT` cycles. A mismatch occurs when the sample ≠ XOR of the 8 data bits (even parity); hold that as a pending mismatch.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - Sample 0: set `frame_err`, discard the byte, go to WAIT_IDLE. A frame error takes precedence; `parity_err` is not also set.
    - Sample 1 with a pending parity mismatch: set `parity_err`, discard the byte, go to IDLE.
    - Sample 1, parity good: push the byte and go to IDLE.
  - WAIT_IDLE: stay until `rxd_s`=1, then go to IDLE. This prevents a break condition from re-triggering as a stream of frames.
- **FIFO.** Read and write pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.
  - Push when full with no pop in the same cycle: drop the byte and set `overrun`.
  - Push and `rd_en` in the same cycle while full: both occur, the count is unchanged, no overrun.
  - Push and `rd_en` in the same cycle while empty: `rd_en` is ignored and the push lands.
- **Sticky flags.** A set wins over `err_clr` in the same cycle.
- **Reset.** Applies at any time, including mid-frame. State goes to IDLE, the FIFO empties, all flags clear, and the partial byte is lost.

## Timing
- **Reset values.** `rd_data`=8'h00, `rx_empty`=1, `rx_full`=0, `overrun`=0, `parity_err`=0, `frame_err`=0.
- **Synchroniser latency.** 2 cycles from an `rxd` edge to `rxd_s`.
- **Sample times.** Let cycle t be the cycle IDLE sees `rxd_s`=0.
  - Start sample at t+`CLKS_PER_BIT`/2.
  - Data bit k sample at t+`CLKS_PER_BIT`/2+(k+1)·`CLKS_PER_BIT`.
  - Parity sample at t+`CLKS_PER_BIT`/2+9·`CLKS_PER_BIT`.
  - Stop sample one bit period after the last sampled bit.
- **Push timing.** The push is registered on the stop-sample edge. `rx_empty` falls and `rd_data` is valid in the following cycle.
- **Pop timing.** `rd_en` with a non-empty FIFO advances `rd_data` in the next cycle.
- **Back-to-back frames.** IDLE is re-entered at mid stop bit. A new start edge arriving half a bit later is accepted, so consecutive frames need no idle gap.
- **Flags.** Each flag asserts the cycle after its triggering sample edge. `err_clr` takes effect the next cycle.

## Test plan
1. **Good frame.** Defaults. Drive 8'h0F with parity 0 and stop 1, at 16 clk per bit. Expect `rx_empty` to fall one cycle after the stop sample, `rd_data`=8'h0F, and all flags 0. Pulse `rd_en`; expect `rx_empty`=1.
2. **Parity error.** Send 8'hA5 with parity 1. Expect `parity_err`=1, `rx_empty` still 1, `frame_err`=0. Pulse `err_clr`; expect `parity_err`=0 next cycle.
3. **Framing and break.** Send 8'h3C with stop bit 0, then hold `rxd` low for 40 bit times. Expect `frame_err`=1, no push, and the FSM in WAIT_IDLE. Release `rxd` high, then send 8'h55; expect 8'h55 received.
4. **Overrun.** Send 5 back-to-back frames 8'h01..8'h05 with no reads. Expect `rx_full`=1 after the 4th and `overrun`=1 after the 5th. Reads return 01, 02, 03, 04, then `rx_empty`=1.
5. **Glitch and push/pop collision.** Pulse `rxd` low for 3 clk; expect no frame and no flags. With the FIFO full, assert `rd_en` on the push cycle; expect no overrun and the count to stay 4.
6. **Mid-frame reset.** Assert `rst` during DATA bit 4. Expect all outputs back at reset values immediately. Then send 8'hC3; expect 8'hC3 received.
